// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the CPU instruction port, CPU data port and the shared downstream
//   memory port handled by mem_port_arbiter.
//   inst_* : fetch request (read, addr) / completion (resp, rdata)
//   data_* : load/store request (read, write, mbe, addr, wdata) / completion (resp, rdata)
//   mem_*  : shared memory strobes (read, write, mbe, addr, wdata) / completion (resp, rdata)
//   Modports: slave  - the arbiter (consumes CPU requests, drives mem_*)
//             master - the CPU/memory environment around the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_read;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_resp;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_read;
  logic                  data_write;
  logic [DATA_W/8-1:0]   data_mbe;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_resp;
  logic [DATA_W-1:0]     data_rdata;

  logic                  mem_read;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_mbe;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_resp;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  inst_read, inst_addr,
    output inst_resp, inst_rdata,
    input  data_read, data_write, data_mbe, data_addr, data_wdata,
    output data_resp, data_rdata,
    output mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport master (
    output inst_read, inst_addr,
    input  inst_resp, inst_rdata,
    output data_read, data_write, data_mbe, data_addr, data_wdata,
    input  data_resp, data_rdata,
    input  mem_read, mem_write, mem_mbe, mem_addr, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one word-wide memory port between the CPU instruction port and the
//   CPU data port. A granted request is latched for the whole transaction, the
//   downstream completion is routed back to the granted requester only, and one
//   IDLE cycle follows every response so a request still held during its resp
//   cycle is not issued twice.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (inst_*, data_*, mem_* signals)
// Build option
//   ARB_ROUND_ROBIN_EN : when defined, simultaneous requests alternate using
//                        last_grant; otherwise data has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {GRANT_INST, GRANT_DATA} grant_e;

  state_e              state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [MBE_W-1:0]    mbe_q, mbe_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic inst_req;
  logic data_req;
  logic pick_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    mbe_d        = mbe_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    inst_req = bus.inst_read;
    data_req = bus.data_read | bus.data_write;
`ifdef ARB_ROUND_ROBIN_EN
    // Contended: serve whoever did not win last time; uncontended: serve at once.
    pick_data = data_req & (~inst_req | (last_grant_q == GRANT_INST));
`else
    pick_data = data_req;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_DATA;
          // Read+write together is taken as a write.
          rd_d         = bus.data_read & ~bus.data_write;
          wr_d         = bus.data_write;
          mbe_d        = bus.data_mbe;
          addr_d       = bus.data_addr;
          wdata_d      = bus.data_wdata;
        end else if (inst_req) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_INST;
          rd_d         = 1'b1;
          wr_d         = 1'b0;
          mbe_d        = '1;
          addr_d       = bus.inst_addr;
          wdata_d      = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        // Completes even if the requester dropped its request meanwhile.
        if (bus.mem_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          mbe_d   = '0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INST;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mbe_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      mbe_q        <= mbe_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;
  assign bus.mem_mbe    = mbe_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

  assign bus.inst_resp  = (state_q == SERVE_I) & bus.mem_resp;
  assign bus.data_resp  = (state_q == SERVE_D) & bus.mem_resp;
  assign bus.inst_rdata = bus.mem_rdata;
  assign bus.data_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [3:0]  dm;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        mr;
    logic [31:0] mrd;
    logic        e_rd;
    logic        e_wr;
    logic [3:0]  e_mbe;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iresp;
    logic        e_dresp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus_if.inst_read  = v.ir;
    bus_if.inst_addr  = v.ia;
    bus_if.data_read  = v.dr;
    bus_if.data_write = v.dw;
    bus_if.data_mbe   = v.dm;
    bus_if.data_addr  = v.da;
    bus_if.data_wdata = v.dwd;
    bus_if.mem_resp   = v.mr;
    bus_if.mem_rdata  = v.mrd;
  endtask

  // Grant order bookkeeping for the contention sequence
`ifdef ARB_ROUND_ROBIN_EN
  localparam int NG = 5;
  logic        exp_is_d [NG] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] exp_ga   [NG] = '{32'h10, 32'h300, 32'h14, 32'h300, 32'h18};
`else
  localparam int NG = 4;
  logic        exp_is_d [NG] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] exp_ga   [NG] = '{32'h10, 32'h14, 32'h18, 32'h300};
`endif

  initial begin
    vec_t z;
    int g, dn, busy;
    logic resp_now, last_was_d;

    n_checks = 0;
    n_errors = 0;
    z = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0,
          1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0};

    // ir ia dr dw dm da dwd mr mrd | rd wr mbe addr wdata iresp dresp
    tbl.push_back(z);  // reset state
    // fetch with 3-cycle-later mem_resp
    tbl.push_back('{1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,            0, 0, 4'h0, 32'h0,  0, 0, 0});
    tbl.push_back('{1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h60, 0, 0, 0});
    tbl.push_back('{1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h60, 0, 0, 0});
    tbl.push_back('{1, 32'h60, 0, 0, 4'h0, 0, 0, 0, 0,            1, 0, 4'hF, 32'h60, 0, 0, 0});
    tbl.push_back('{1, 32'h60, 0, 0, 4'h0, 0, 0, 1, 32'h13,       1, 0, 4'hF, 32'h60, 0, 1, 0});
    tbl.push_back(z);
    // mem_resp while idle is ignored
    tbl.push_back('{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h55,            0, 0, 4'h0, 32'h0,  0, 0, 0});
    // simultaneous inst read / data write: data first, idle gap, then inst
    tbl.push_back('{1, 32'h100, 0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0, 0});
    tbl.push_back('{1, 32'h100, 0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0, 0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 0});
    tbl.push_back('{1, 32'h100, 0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 1, 0, 0, 1, 4'h3, 32'h200, 32'hDEADBEEF, 0, 1});
    tbl.push_back('{1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0,           0, 0, 4'h0, 32'h0,  0, 0, 0});
    tbl.push_back('{1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0,           1, 0, 4'hF, 32'h100, 0, 0, 0});
    tbl.push_back('{1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 32'hCAFE0001, 1, 0, 4'hF, 32'h100, 0, 1, 0});
    tbl.push_back(z);
    // read+write together is a write
    tbl.push_back('{0, 0, 1, 1, 4'hF, 32'h80, 32'h12345678, 0, 0, 0, 0, 4'h0, 32'h0,  0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 4'hF, 32'h80, 32'h12345678, 0, 0, 0, 1, 4'hF, 32'h80, 32'h12345678, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 4'hF, 32'h80, 32'h12345678, 1, 0, 0, 1, 4'hF, 32'h80, 32'h12345678, 0, 1});
    tbl.push_back(z);
    // request fields change mid-transaction: latched copy is held
    tbl.push_back('{0, 0, 1, 0, 4'hF, 32'h44, 32'hAAAA5555, 0, 0, 0, 0, 4'h0, 32'h0,  0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'h1, 32'h48, 32'h11111111, 0, 0, 1, 0, 4'hF, 32'h44, 32'hAAAA5555, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'h2, 32'h4C, 32'h22222222, 0, 0, 1, 0, 4'hF, 32'h44, 32'hAAAA5555, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 4'h2, 32'h4C, 32'h22222222, 1, 32'h77, 1, 0, 4'hF, 32'h44, 32'hAAAA5555, 0, 1});
    tbl.push_back(z);
    // request dropped before mem_resp still completes with a resp pulse
    tbl.push_back('{0, 0, 1, 0, 4'hF, 32'h90, 0, 0, 0,            0, 0, 4'h0, 32'h0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,                 1, 0, 4'hF, 32'h90, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h99,            1, 0, 4'hF, 32'h90, 0, 0, 1});
    tbl.push_back(z);

    rst = 1'b1;
    drive(z);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d mem_read", i),  {31'b0, bus_if.mem_read},  {31'b0, tbl[i].e_rd});
      chk($sformatf("v%0d mem_write", i), {31'b0, bus_if.mem_write}, {31'b0, tbl[i].e_wr});
      chk($sformatf("v%0d mem_mbe", i),   {28'b0, bus_if.mem_mbe},   {28'b0, tbl[i].e_mbe});
      chk($sformatf("v%0d mem_addr", i),  bus_if.mem_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d mem_wdata", i), bus_if.mem_wdata,          tbl[i].e_wdata);
      chk($sformatf("v%0d inst_resp", i), {31'b0, bus_if.inst_resp}, {31'b0, tbl[i].e_iresp});
      chk($sformatf("v%0d data_resp", i), {31'b0, bus_if.data_resp}, {31'b0, tbl[i].e_dresp});
      if (tbl[i].e_iresp) chk($sformatf("v%0d inst_rdata", i), bus_if.inst_rdata, tbl[i].mrd);
      if (tbl[i].e_dresp) chk($sformatf("v%0d data_rdata", i), bus_if.data_rdata, tbl[i].mrd);
    end

    // Reset in the middle of a data read
    @(negedge clk);
    drive(z);
    bus_if.data_read = 1'b1;
    bus_if.data_addr = 32'h40;
    bus_if.data_mbe  = 4'hF;
    #1;
    chk("rst_mid idle mem_read", {31'b0, bus_if.mem_read}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_mid serve mem_read", {31'b0, bus_if.mem_read}, 32'd1);
    chk("rst_mid serve mem_addr", bus_if.mem_addr, 32'h40);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid rst-cycle data_resp", {31'b0, bus_if.data_resp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(z);
    #1;
    chk("rst_mid after mem_read", {31'b0, bus_if.mem_read}, 32'd0);
    chk("rst_mid after mem_addr", bus_if.mem_addr, 32'h0);
    chk("rst_mid after mem_mbe", {28'b0, bus_if.mem_mbe}, 32'h0);
    chk("rst_mid after data_resp", {31'b0, bus_if.data_resp}, 32'd0);
    @(negedge clk);
    bus_if.mem_resp  = 1'b1;
    bus_if.mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("rst_mid late resp data_resp", {31'b0, bus_if.data_resp}, 32'd0);
    chk("rst_mid late resp inst_resp", {31'b0, bus_if.inst_resp}, 32'd0);
    @(negedge clk);
    bus_if.mem_resp = 1'b0;
    #1;
    chk("rst_mid late resp mem_read", {31'b0, bus_if.mem_read}, 32'd0);
    chk("rst_mid late resp mem_write", {31'b0, bus_if.mem_write}, 32'd0);

    // Held fetch against three back-to-back data reads
    @(negedge clk);
    drive(z);
    bus_if.inst_read = 1'b1;
    bus_if.inst_addr = 32'h300;
    bus_if.data_read = 1'b1;
    bus_if.data_addr = 32'h10;
    bus_if.data_mbe  = 4'hF;
    g = 0; dn = 0; busy = 0; resp_now = 1'b0; last_was_d = 1'b0;
    for (int cyc = 0; cyc < 80 && (g < NG || busy != 0 || resp_now); cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (resp_now) begin
        resp_now = 1'b0;
        if (last_was_d) begin
          dn++;
          if (dn >= 3) bus_if.data_read = 1'b0;
          else bus_if.data_addr = 32'h10 + 32'(4 * dn);
        end
        if (g >= NG) bus_if.inst_read = 1'b0;
      end
      bus_if.mem_resp = 1'b0;
      #1;
      if (busy == 0 && (bus_if.mem_read || bus_if.mem_write)) begin
        last_was_d = (bus_if.mem_addr != 32'h300);
        if (g < NG) begin
          chk($sformatf("rr grant%0d is_data", g), {31'b0, last_was_d}, {31'b0, exp_is_d[g]});
          chk($sformatf("rr grant%0d addr", g), bus_if.mem_addr, exp_ga[g]);
        end else begin
          chk($sformatf("rr extra grant%0d", g), 32'd1, 32'd0);
        end
        g++;
        busy = 1;
      end else if (busy == 1) begin
        bus_if.mem_resp  = 1'b1;
        bus_if.mem_rdata = 32'h1000 + 32'(g);
        #1;
        chk($sformatf("rr resp%0d to granted side", g - 1),
            {30'b0, bus_if.data_resp, bus_if.inst_resp},
            last_was_d ? 32'd2 : 32'd1);
        busy = 0;
        resp_now = 1'b1;
      end
    end
    chk("rr grant count", 32'(g), 32'(NG));
    @(negedge clk);
    drive(z);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
